// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: read-side consumer of a FIFO that serializes each popped word
// onto a UART line, LSB first (start bit, DBIT data bits, SBIT stop bits).
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert one even-parity
// bit between the last data bit and the first stop bit.
module fifo_uart_tx #(
  parameter int DBIT         = 8,
  parameter int SBIT         = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tx_en,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            busy
);

  // The counter must reach the longest interval, which is the stop period.
  localparam int STOP_LEN = SBIT * CLKS_PER_BIT;
  localparam int CW       = $clog2(STOP_LEN);
  localparam int NW       = $clog2(DBIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [NW-1:0] NB_LAST   = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [NW-1:0]   nb_reg, nb_next;
  logic [DBIT-1:0] shreg_reg, shreg_next;
  logic            tx_reg, tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            par_reg, par_next;
`endif

  // Pop strobe: only from IDLE, never while reset is held.
  assign rd   = (state_reg == IDLE) & tx_en & ~empty & reset_n;
  assign busy = (state_reg != IDLE);
  assign tx   = tx_reg;

  // State register; reset returns the line to idle-high and drops any word in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      nb_reg    <= '0;
      shreg_reg <= '0;
      tx_reg    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      nb_reg    <= nb_next;
      shreg_reg <= shreg_next;
      tx_reg    <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // Next-state and datapath: each bit lasts CLKS_PER_BIT cycles, tx is set
  // one edge ahead so the registered line changes exactly on bit boundaries.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    nb_next    = nb_reg;
    shreg_next = shreg_reg;
    tx_next    = tx_reg;
`ifdef FIFO_UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (rd) begin
          shreg_next = r_data;
          cnt_next   = '0;
          tx_next    = 1'b0;
          state_next = START;
`ifdef FIFO_UART_TX_PARITY_EN
          par_next   = ^r_data;
`endif
        end
      end
      START: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          nb_next    = '0;
          tx_next    = shreg_reg[0];
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shreg_next = shreg_reg >> 1;
          nb_next    = nb_reg + NW'(1);
          if (nb_reg == NB_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_next    = par_reg;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            tx_next = shreg_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_reg == STOP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
